// File: rtl/switch_event_arbiter.sv
// switch_event_arbiter: turns N debounced switch levels into a serialised
// stream of press / auto-repeat events on a valid/ready handshake.
module switch_event_arbiter #(
    parameter int unsigned N_SW          = 4,
    parameter int unsigned ID_W          = 2,
    parameter int unsigned REPEAT_DELAY  = 12500000,
    parameter int unsigned REPEAT_PERIOD = 2500000,
    parameter int unsigned CNT_W         = 24
) (
    input  logic            i_Clk,
    input  logic            i_Reset,
    input  logic [N_SW-1:0] i_Switch,
    input  logic            i_Repeat_En,
    output logic            o_Event_Valid,
    input  logic            i_Event_Ready,
    output logic [ID_W-1:0] o_Event_Id,
    output logic            o_Event_Repeat,
    output logic            o_Drop,
    output logic [7:0]      o_Drop_Count
);

    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [ID_W-1:0]  LAST_INIT   = ID_W'(N_SW - 1);

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    rpt_state_t       r_State, state_next;
    logic [CNT_W-1:0] r_Cnt, cnt_next;
    logic [ID_W-1:0]  r_Trk, trk_next;
    logic             tick;

    logic [N_SW-1:0]  r_Prev, r_Pend, r_Pend_Rpt;
    logic [ID_W-1:0]  r_Last;

    logic [N_SW-1:0]  rise;
    logic             rise_any;
    logic [ID_W-1:0]  rise_low;
    logic             grant_any, hi_found, lo_found;
    logic [ID_W-1:0]  grant_idx, hi_idx, lo_idx;
    logic             load;
    logic [N_SW-1:0]  set_req, set_rpt, xfer, drop_vec, pend_next, pend_rpt_next;

    // Rising-edge detect and lowest rising index (used to (re)target repeat)
    always_comb begin
        rise     = i_Switch & ~r_Prev;
        rise_any = |rise;
        rise_low = '0;
        for (int i = int'(N_SW) - 1; i >= 0; i--) begin
            if (rise[i]) rise_low = ID_W'(i);
        end
    end

    // Repeat FSM state register
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_State <= RPT_IDLE;
            r_Cnt   <= '0;
            r_Trk   <= '0;
        end else begin
            r_State <= state_next;
            r_Cnt   <= cnt_next;
            r_Trk   <= trk_next;
        end
    end

    // Repeat FSM next state: release beats retarget beats tick
    always_comb begin
        state_next = r_State;
        cnt_next   = r_Cnt;
        trk_next   = r_Trk;
        tick       = 1'b0;
        if (!i_Repeat_En) begin
            state_next = RPT_IDLE;
            cnt_next   = '0;
        end else begin
            case (r_State)
                RPT_IDLE: begin
                    if (rise_any) begin
                        state_next = RPT_DELAY;
                        trk_next   = rise_low;
                        cnt_next   = '0;
                    end
                end
                RPT_DELAY, RPT_REPEAT: begin
                    if (!i_Switch[r_Trk]) begin
                        state_next = RPT_IDLE;
                        cnt_next   = '0;
                    end else if (rise_any) begin
                        state_next = RPT_DELAY;
                        trk_next   = rise_low;
                        cnt_next   = '0;
                    end else if (r_Cnt == ((r_State == RPT_DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
                        tick       = 1'b1;
                        cnt_next   = '0;
                        state_next = RPT_REPEAT;
                    end else begin
                        cnt_next = r_Cnt + 1'b1;
                    end
                end
                default: begin
                    state_next = RPT_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Round-robin search starting just above the last grant, wrapping to 0
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < int'(N_SW); i++) begin
            if (r_Pend[i] && !hi_found && (ID_W'(i) > r_Last)) begin
                hi_found = 1'b1;
                hi_idx   = ID_W'(i);
            end
            if (r_Pend[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = ID_W'(i);
            end
        end
        grant_any = hi_found | lo_found;
        grant_idx = hi_found ? hi_idx : lo_idx;
    end

    // Pending-flag update: a set request on a transferring bit wins, on a
    // still-pending bit it is dropped
    always_comb begin
        load = ~o_Event_Valid | i_Event_Ready;
        for (int i = 0; i < int'(N_SW); i++) begin
            set_req[i]       = rise[i] | (tick & (r_Trk == ID_W'(i)));
            set_rpt[i]       = ~rise[i];
            xfer[i]          = load & grant_any & (grant_idx == ID_W'(i));
            drop_vec[i]      = set_req[i] & r_Pend[i] & ~xfer[i];
            pend_next[i]     = set_req[i] | (r_Pend[i] & ~xfer[i]);
            pend_rpt_next[i] = (set_req[i] & ~drop_vec[i]) ? set_rpt[i] : r_Pend_Rpt[i];
        end
    end

    // Edge history, pending flags, output event register and drop counter
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_Prev         <= i_Switch;
            r_Pend         <= '0;
            r_Pend_Rpt     <= '0;
            r_Last         <= LAST_INIT;
            o_Event_Valid  <= 1'b0;
            o_Event_Id     <= '0;
            o_Event_Repeat <= 1'b0;
            o_Drop         <= 1'b0;
            o_Drop_Count   <= '0;
        end else begin
            r_Prev     <= i_Switch;
            r_Pend     <= pend_next;
            r_Pend_Rpt <= pend_rpt_next;
            o_Drop     <= |drop_vec;
            if ((|drop_vec) && (o_Drop_Count != 8'hFF)) begin
                o_Drop_Count <= o_Drop_Count + 8'd1;
            end
            if (load) begin
                o_Event_Valid <= grant_any;
                if (grant_any) begin
                    o_Event_Id     <= grant_idx;
                    o_Event_Repeat <= r_Pend_Rpt[grant_idx];
                    r_Last         <= grant_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_event_arbiter.sv
// Bench for switch_event_arbiter: directed scenarios plus random traffic,
// all cycles checked against a cycle-level reference model.
module tb_switch_event_arbiter;

    localparam int N = 4;
    localparam int D = 20;
    localparam int P = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw;
    logic       rep_en;
    logic       ready;
    logic       o_Event_Valid;
    logic [1:0] o_Event_Id;
    logic       o_Event_Repeat;
    logic       o_Drop;
    logic [7:0] o_Drop_Count;

    always #5 clk = ~clk;

    switch_event_arbiter #(
        .N_SW(4), .ID_W(2), .REPEAT_DELAY(D), .REPEAT_PERIOD(P), .CNT_W(8)
    ) dut (
        .i_Clk(clk),
        .i_Reset(rst),
        .i_Switch(sw),
        .i_Repeat_En(rep_en),
        .o_Event_Valid(o_Event_Valid),
        .i_Event_Ready(ready),
        .o_Event_Id(o_Event_Id),
        .o_Event_Repeat(o_Event_Repeat),
        .o_Drop(o_Drop),
        .o_Drop_Count(o_Drop_Count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: pending sets, output slot, and a held-switch age
    bit m_prev[N];
    bit m_pend[N];
    bit m_prpt[N];
    bit m_valid, m_rpt, m_drop;
    int m_id, m_last, m_dcnt, m_trk, m_age;

    // Observed event tallies for scenario-level checks
    int ev_seen;
    int rpt_seen[N];
    int exp_ids[3] = '{0, 1, 3};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_tally();
        ev_seen = 0;
        for (int i = 0; i < N; i++) rpt_seen[i] = 0;
    endtask

    // One clock edge of the reference model, from the inputs sampled there
    task automatic model_edge();
        bit rise[N];
        int lowr, g, ti, j;
        bit tick, load, drop, setr, xf;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_prev[i] = sw[i];
                m_pend[i] = 1'b0;
                m_prpt[i] = 1'b0;
            end
            m_valid = 0; m_rpt = 0; m_drop = 0;
            m_id = 0; m_last = N - 1; m_dcnt = 0; m_trk = -1; m_age = 0;
            return;
        end
        lowr = -1;
        for (int i = 0; i < N; i++) begin
            rise[i] = sw[i] && !m_prev[i];
            if (rise[i] && lowr < 0) lowr = i;
        end
        tick = 0;
        if (!rep_en) begin
            m_trk = -1;
        end else if (m_trk < 0) begin
            if (lowr >= 0) begin m_trk = lowr; m_age = 0; end
        end else if (!sw[m_trk]) begin
            m_trk = -1;
        end else if (lowr >= 0) begin
            m_trk = lowr; m_age = 0;
        end else begin
            m_age++;
            if (m_age == D || (m_age > D && (m_age - D) % P == 0)) tick = 1;
        end
        ti = m_trk;
        g = -1;
        for (int off = 1; off <= N; off++) begin
            j = (m_last + off) % N;
            if (g < 0 && m_pend[j]) g = j;
        end
        load = !m_valid || ready;
        if (load) begin
            m_valid = (g >= 0);
            if (g >= 0) begin
                m_id = g; m_rpt = m_prpt[g]; m_last = g;
            end
        end
        drop = 0;
        for (int i = 0; i < N; i++) begin
            setr = rise[i] || (tick && ti == i);
            xf   = load && (g == i);
            if (setr && m_pend[i] && !xf) begin
                drop = 1;
            end else if (setr) begin
                m_pend[i] = 1; m_prpt[i] = !rise[i];
            end else if (xf) begin
                m_pend[i] = 0;
            end
            m_prev[i] = sw[i];
        end
        m_drop = drop;
        if (drop && m_dcnt < 255) m_dcnt++;
    endtask

    // Advance one clock, update the model, then compare just after the edge
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("valid", o_Event_Valid, m_valid);
        if (m_valid) begin
            check("id", o_Event_Id, m_id);
            check("repeat", o_Event_Repeat, m_rpt);
        end
        check("drop", o_Drop, m_drop);
        check("drop_count", o_Drop_Count, m_dcnt);
        if (o_Event_Valid) begin
            ev_seen++;
            if (o_Event_Repeat) rpt_seen[o_Event_Id]++;
        end
    endtask

    initial begin
        rst = 1; sw = '0; rep_en = 0; ready = 1;
        clear_tally();
        step(); step();
        check("reset_valid", o_Event_Valid, 0);
        check("reset_dcnt", o_Drop_Count, 0);
        rst = 0;
        step();

        // Single press: one event, two edges after the press is sampled
        sw[2] = 1; step();
        check("press_lat", o_Event_Valid, 0);
        step();
        check("press_valid", o_Event_Valid, 1);
        check("press_id", o_Event_Id, 2);
        check("press_rpt", o_Event_Repeat, 0);
        step();
        check("press_once", o_Event_Valid, 0);
        repeat (2) step();
        sw[2] = 0;
        repeat (3) step();

        // Simultaneous presses, twice: order restarts at 0 each time
        rst = 1; step(); rst = 0; step();
        for (int r = 0; r < 2; r++) begin
            sw = 4'b1011; step();
            for (int k = 0; k < 3; k++) begin
                step();
                check("simul_valid", o_Event_Valid, 1);
                check("simul_id", o_Event_Id, exp_ids[k]);
            end
            sw = '0; step(); step();
        end

        // Backpressure: held output, re-press after transfer, then a drop
        ready = 0;
        sw[1] = 1; step(); step();
        check("bp_valid", o_Event_Valid, 1);
        check("bp_id", o_Event_Id, 1);
        sw[1] = 0; step();
        sw[1] = 1; step();
        check("bp_nodrop", o_Drop, 0);
        check("bp_hold_id", o_Event_Id, 1);
        sw[1] = 0; step();
        sw[1] = 1; step();
        check("bp_drop", o_Drop, 1);
        check("bp_dcnt", o_Drop_Count, 1);
        step();
        check("bp_drop_pulse", o_Drop, 0);
        sw[1] = 0; ready = 1;
        repeat (4) step();

        // Auto-repeat on a 60-cycle hold: 1 press + ticks at 20,28,36,44,52
        rep_en = 1; clear_tally();
        sw[2] = 1;
        repeat (60) step();
        sw[2] = 0;
        repeat (30) step();
        check("ar_events", ev_seen, 6);
        check("ar_repeats", rpt_seen[2], 5);

        // Retarget to switch 3, then disable repeat
        clear_tally();
        sw[0] = 1; repeat (10) step();
        sw[3] = 1; repeat (45) step();
        rep_en = 0; repeat (20) step();
        check("rt_rep0", rpt_seen[0], 0);
        check("rt_rep3", rpt_seen[3], 4);
        check("rt_events", ev_seen, 6);
        sw = '0; repeat (3) step();

        // Reset mid-operation with an event in flight and one pending
        ready = 0;
        sw[1] = 1; step(); step();
        sw[0] = 1; step();
        rst = 1; step();
        check("rst_mid_valid", o_Event_Valid, 0);
        check("rst_mid_id", o_Event_Id, 0);
        check("rst_mid_dcnt", o_Drop_Count, 0);
        rst = 0; sw[0] = 0; ready = 1; clear_tally();
        repeat (5) step();
        check("rst_no_event", ev_seen, 0);
        sw[1] = 0; step();
        sw[1] = 1; step(); step();
        check("rst_toggle_valid", o_Event_Valid, 1);
        check("rst_toggle_id", o_Event_Id, 1);

        // Random traffic against the model
        rep_en = 1;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 31) == 0) sw[b] = ~sw[b];
            end
            ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) rep_en = ~rep_en;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_event_arbiter.md
Name: switch_event_arbiter

Overview:
- Converts N debounced switch/button levels into a single stream of press events on a valid/ready handshake.
- Detects rising edges and holds one pending flag per switch. A round-robin arbiter serialises simultaneous presses.
- One shared auto-repeat engine generates repeat events for a held switch.
- Sits between the per-button debounce instances and the game/control FSM that consumes button events.

Parameters:
- N_SW, 4, number of switch inputs (2..16).
- ID_W, 2, event id width; must satisfy 2^ID_W >= N_SW.
- REPEAT_DELAY, 12500000, cycles a switch must be held before the first repeat (500 ms at 25 MHz); must be >= 2.
- REPEAT_PERIOD, 2500000, cycles between subsequent repeats (100 ms at 25 MHz); must be >= 2.
- CNT_W, 24, repeat counter width; must hold max(REPEAT_DELAY, REPEAT_PERIOD)-1.

Ports:
- i_Clk  in  1  system clock.
- i_Reset  in  1  reset.
- i_Switch  in  N_SW  debounced switch levels, already synchronous to i_Clk.
- i_Repeat_En  in  1  enables auto-repeat; 0 forces repeat FSM to IDLE.
- o_Event_Valid  out  1  event available.
- i_Event_Ready  in  1  consumer accepts event when high with o_Event_Valid.
- o_Event_Id  out  ID_W  index of switch that produced the event.
- o_Event_Repeat  out  1  0 = initial press, 1 = auto-repeat.
- o_Drop  out  1  one-cycle pulse: an event was lost because its switch was already pending.
- o_Drop_Count  out  8  saturating count of dropped events (stops at 255).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are i_Clk and i_Reset.
- Reset:
  - All outputs 0; pending flags 0; last-grant pointer = N_SW-1, so the first search starts at index 0.
  - Repeat FSM in IDLE, counter 0.
  - r_Prev loads i_Switch during reset. A switch held through reset therefore produces no event.
- Edge detect:
  - rise[i] = i_Switch[i] & ~r_Prev[i], combinational.
  - r_Prev <= i_Switch every cycle.
- Pending set:
  - At the edge where rise[i]=1: pend[i]<=1, pend_rpt[i]<=0.
  - A repeat tick for index k sets pend[k]<=1, pend_rpt[k]<=1.
- Drop:
  - A set request on a bit already pending, and not being transferred to the output register this cycle, is discarded.
  - The discard pulses o_Drop for 1 cycle and increments o_Drop_Count.
  - Multiple drops in one cycle count as 1.
- Output register:
  - Loads when ~o_Event_Valid | i_Event_Ready.
  - Load target: first index j with pend[j]=1, searching (last_grant+1) mod N_SW upward with wrap.
  - At that edge: o_Event_Valid<=1, o_Event_Id<=j, o_Event_Repeat<=pend_rpt[j], pend[j]<=0, last_grant<=j.
  - If nothing is pending, o_Event_Valid<=0.
- Simultaneous set and transfer on the same bit: the set wins. The old event moves to output and the new one stays pending. No drop.
- While o_Event_Valid=1 and i_Event_Ready=0, o_Event_Id and o_Event_Repeat are held stable.
- Latency: rise sampled at edge k sets pending at k. o_Event_Valid rises at edge k+1 if the output register is free.
- Repeat FSM (one shared engine; tracked index r_Trk):
  - IDLE: any rise → r_Trk = lowest index with rise, cnt=0, go to DELAY.
  - DELAY:
    - If i_Switch[r_Trk]=0 → IDLE.
    - Else if any rise on another index → retarget: r_Trk = lowest rising index, cnt=0, stay in DELAY.
    - Else if cnt==REPEAT_DELAY-1 → tick, cnt=0, go to REPEAT.
    - Else cnt+1.
  - REPEAT:
    - Release → IDLE.
    - A rise elsewhere → retarget, go to DELAY.
    - cnt==REPEAT_PERIOD-1 → tick, cnt=0.
    - Else cnt+1.
  - Release is checked before tick; no tick occurs in the release cycle.
  - i_Repeat_En=0 → state<=IDLE, cnt<=0. Edge events are unaffected.
- Reset asserted mid-operation discards the in-flight output event and all pending flags at the next edge.

Test Plan:
- Single press, with N_SW=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, i_Event_Ready=1:
  - Raise i_Switch[2] for 5 cycles → exactly one event, Id=2, Repeat=0.
  - o_Event_Valid is high for 1 cycle, 2 edges after i_Switch[2] is sampled high.
- Simultaneous presses:
  - Raise switches 0, 1 and 3 in the same cycle with ready=1 → events Id 0, 1, 3 on consecutive cycles.
  - Repeat the stimulus → order starts at 0 again (last_grant=3 wraps).
- Backpressure:
  - Hold ready=0, press 1 → Valid stays 1, Id stays 1.
  - Release 1 and press 1 again while stalled → no drop, since the bit was already transferred.
  - Press a third time → o_Drop pulses and o_Drop_Count=1.
- Auto-repeat, i_Repeat_En=1:
  - Hold switch 2 for 60 cycles → initial event.
  - Repeat events at 20 and 28 cycles after the press edge, then every 8 cycles.
  - Release → no further repeats.
- Retarget and disable:
  - Hold 0, then press 3 after 10 cycles → repeat ticks only for Id 3, starting 20 cycles after its press.
  - Drop i_Repeat_En → no repeats.
- Reset:
  - Hold switch 1 and assert i_Reset with an event pending and ready=0 → all outputs 0 next cycle.
  - After release no event for switch 1 until it toggles.
